rps_match_ctrl: RTL and testbench
=================================

// Module: rps_match_ctrl
// PURPOSE
//  Match sequencer for the rock-paper-scissors game datapath.
//  - Collects one move per player per round over valid/ready handshakes.
//  - Judges each round using the one-hot move encoding and the {A wins, B wins} result format of the round judge.
//  - Keeps running scores and ends the match when either player reaches WIN_TARGET round wins.
//  - Sits between the player input front-ends and the score display / top level.
// PARAMETERS
//  WIN_TARGET  3   round wins needed to take the match (1..2**SCORE_W-1)
//  SCORE_W     3   width of each score counter
//  TIMEOUT     15  max cycles in COLLECT before missing players forfeit the round (>=2)
// PORTS
//  clk           in   1        single clock; all state changes on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        begin new match; honoured only in IDLE or DONE
//  a_valid       in   1        player A move offered
//  a_move        in   3        A move, one-hot: 100 rock, 010 paper, 001 scissors
//  a_ready       out  1        controller accepts A move this cycle
//  b_valid       in   1        player B move offered
//  b_move        in   3        B move, same encoding as a_move
//  b_ready       out  1        controller accepts B move this cycle
//  round_done    out  1        one-cycle pulse: round judged, result and scores updated
//  round_result  out  2        [1]=A won round, [0]=B won round, 00=tie; held until next round_done
//  score_a       out  SCORE_W  A round wins this match
//  score_b       out  SCORE_W  B round wins this match
//  busy          out  1        match in progress (COLLECT/JUDGE/REPORT)
//  match_done    out  1        level; high in DONE
//  winner        out  2        10=A, 01=B; valid while match_done, else 00
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - State=IDLE; all outputs 0; captured moves, flags and timeout counter cleared.
//  States: IDLE, COLLECT, JUDGE, REPORT, DONE.
//  IDLE:
//  - start -> COLLECT; clear scores, round_result and capture flags.
//  COLLECT:
//  - a_ready = !a_have; b_ready = !b_have (combinational from registered state).
//  - A move captured when a_valid & a_ready; sets a_have; later a_valid ignored this round. B likewise.
//  - Both players may be captured in the same cycle.
//  - When both flags are set (including set this cycle) -> JUDGE on the next edge.
//  - Timeout counter starts at 0 on entry and increments each COLLECT cycle.
//  - At count TIMEOUT-1, if a flag is still clear, that player's move is marked invalid and the state goes to JUDGE.
//    A capture made in that same cycle still counts.
//  JUDGE (one cycle), evaluated on captured moves:
//  - A wins: (100,001), (010,100), (001,010). B wins: the mirrored pairs.
//  - Equal valid moves: tie.
//  - Non-one-hot or missing move is invalid and loses to any valid move.
//  - Both invalid: tie.
//  - On exit: round_result registered, winner's score +1, round_done=1, state -> REPORT.
//  REPORT (one cycle, round_done high):
//  - Clear flags and timeout counter.
//  - If score_a or score_b == WIN_TARGET -> DONE, else -> COLLECT.
//  - Latency: last capture in cycle N -> round_done and new scores visible in cycle N+2; next COLLECT in N+3.
//  DONE:
//  - match_done=1; winner set; scores and round_result held.
//  - start -> COLLECT with scores cleared, match_done and winner cleared.
//  Other rules:
//  - busy=1 in COLLECT, JUDGE and REPORT; start is ignored while busy.
//  - Scores never exceed WIN_TARGET; no wrap-around.
//  - Ties add no score; the match continues indefinitely on repeated ties.
//  - rst_n low mid-match: immediate IDLE, scores lost, a_ready=b_ready=0.
// TESTING
//  1. Reset, then hold rst_n=0 -> all outputs 0, a_ready=b_ready=0, busy=0.
//  2. start; A=100 and B=001 same cycle N -> round_done @N+2, round_result=10, score_a=1, score_b=0.
//  3. A=010 @N, B=010 @N+4 -> b_ready stays 1 until N+4, a_ready=0 after N; result=00, scores unchanged.
//  4. A=110 (invalid), B=010 -> result=01, score_b +1. Both invalid -> result=00.
//  5. Only A offers 001; B idle for TIMEOUT=15 cycles -> JUDGE forced, result=10, score_a +1.
//  6. B wins 3 rounds -> match_done=1, winner=01, busy=0; start during COLLECT ignored; rst_n pulse mid-COLLECT -> IDLE, scores 0.

Source files
------------

// File: rtl/rps_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// rps_match_ctrl_if
//   Player move handshake bundle between the two player front-ends and the
//   rock-paper-scissors match controller.
//
//   a_valid / a_move / a_ready : player A move offer (one-hot 100/010/001)
//   b_valid / b_move / b_ready : player B move offer (same encoding)
//
//   master : player side (drives valid/move, observes ready)
//   slave  : controller side (observes valid/move, drives ready)
// -----------------------------------------------------------------------------
interface rps_match_ctrl_if;
  logic       a_valid;
  logic [2:0] a_move;
  logic       a_ready;
  logic       b_valid;
  logic [2:0] b_move;
  logic       b_ready;

  modport master (
    output a_valid, a_move, b_valid, b_move,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_move, b_valid, b_move,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// -----------------------------------------------------------------------------
// rps_match_ctrl
//   Match sequencer for the rock-paper-scissors datapath. Collects one move per
//   player per round, judges the round, keeps running scores and ends the match
//   when a player reaches WIN_TARGET round wins. A player that does not offer a
//   move within TIMEOUT collect cycles forfeits the round.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a new match (honoured in IDLE or DONE only)
//   p             player move handshakes (slave side)
//   round_done    one-cycle pulse when a round has been judged
//   round_result  [1]=A won, [0]=B won, 00=tie; held until next round_done
//   score_a/b     round wins of each player in the current match
//   busy          match in progress (COLLECT/JUDGE/REPORT)
//   match_done    high while in DONE
//   winner        10=A, 01=B while match_done, else 00
// -----------------------------------------------------------------------------
module rps_match_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  rps_match_ctrl_if.slave    p,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         winner
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_JUDGE, S_REPORT, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               a_have, b_have;
  logic [2:0]         a_mv, b_mv;
  logic [CNT_W-1:0]   tcnt;

  logic a_take, b_take, expired, clear_match;
  logic [1:0] verdict;

  // A move beats another only for the three canonical one-hot pairs.
  function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
    return (x == 3'b100 && y == 3'b001) ||
           (x == 3'b010 && y == 3'b100) ||
           (x == 3'b001 && y == 3'b010);
  endfunction

  function automatic logic one_hot3(input logic [2:0] m);
    return (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
  endfunction

  // A missing move (flag clear) is treated the same as a malformed one.
  function automatic logic [1:0] judge(input logic a_ok, input logic [2:0] a,
                                       input logic b_ok, input logic [2:0] b);
    if (a_ok && b_ok) return {beats(a, b), beats(b, a)};
    else if (a_ok)    return 2'b10;
    else if (b_ok)    return 2'b01;
    else              return 2'b00;
  endfunction

  assign p.a_ready = (state == S_COLLECT) && !a_have;
  assign p.b_ready = (state == S_COLLECT) && !b_have;

  assign a_take      = p.a_valid && p.a_ready;
  assign b_take      = p.b_valid && p.b_ready;
  assign expired     = (tcnt == CNT_W'(TIMEOUT - 1));
  assign clear_match = start && (state == S_IDLE || state == S_DONE);
  assign verdict     = judge(a_have && one_hot3(a_mv), a_mv,
                             b_have && one_hot3(b_mv), b_mv);

  assign round_done = (state == S_REPORT);
  assign busy       = (state == S_COLLECT) || (state == S_JUDGE) || (state == S_REPORT);
  assign match_done = (state == S_DONE);
  assign winner     = match_done ? {score_a == TARGET, score_b == TARGET} : 2'b00;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (((a_have || a_take) && (b_have || b_take)) || expired)
                   state_nxt = S_JUDGE;
      S_JUDGE:   state_nxt = S_REPORT;
      S_REPORT:  state_nxt = (score_a == TARGET || score_b == TARGET) ? S_DONE : S_COLLECT;
      S_DONE:    if (start) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_have       <= 1'b0;
      b_have       <= 1'b0;
      a_mv         <= '0;
      b_mv         <= '0;
      tcnt         <= '0;
      score_a      <= '0;
      score_b      <= '0;
      round_result <= '0;
    end else if (clear_match) begin
      a_have       <= 1'b0;
      b_have       <= 1'b0;
      tcnt         <= '0;
      score_a      <= '0;
      score_b      <= '0;
      round_result <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (a_take) begin
            a_have <= 1'b1;
            a_mv   <= p.a_move;
          end
          if (b_take) begin
            b_have <= 1'b1;
            b_mv   <= p.b_move;
          end
          tcnt <= tcnt + CNT_W'(1);
        end
        S_JUDGE: begin
          round_result <= verdict;
          if (verdict[1] && score_a != TARGET) score_a <= score_a + SCORE_W'(1);
          if (verdict[0] && score_b != TARGET) score_b <= score_b + SCORE_W'(1);
        end
        S_REPORT: begin
          a_have <= 1'b0;
          b_have <= 1'b0;
          tcnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rps_match_ctrl
//   Directed bench for rps_match_ctrl: a table of rounds with hand-computed
//   results plus hand-written sequences for staggered captures, DONE behaviour,
//   start-while-busy and reset mid-match. Inputs change on the falling edge,
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rps_match_ctrl;
  localparam int WIN_TARGET = 3;
  localparam int SCORE_W    = 3;
  localparam int TIMEOUT    = 15;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               round_done;
  logic [1:0]         round_result;
  logic [SCORE_W-1:0] score_a, score_b;
  logic               busy, match_done;
  logic [1:0]         winner;

  rps_match_ctrl_if pif ();

  rps_match_ctrl #(
    .WIN_TARGET(WIN_TARGET), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p(pif),
    .round_done(round_done), .round_result(round_result),
    .score_a(score_a), .score_b(score_b), .busy(busy),
    .match_done(match_done), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] am;
    logic [2:0] bm;
    bit         a_en;
    bit         b_en;
    logic [1:0] res;
  } vec_t;

  vec_t tbl [12];
  int   checks = 0;
  int   errors = 0;
  int   ma = 0;
  int   mb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start pulse: raised on a falling edge, dropped just after the rising edge
  // so the caller is positioned inside the first COLLECT cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ma = 0;
    mb = 0;
  endtask

  // One round from the first COLLECT cycle. Offered players present their move
  // for a single cycle; absent players force the timeout path.
  task automatic play(input vec_t v, input string tag);
    int lat;
    int exp_lat;
    bit seen;
    @(negedge clk);
    check({tag, " ready"}, {31'd0, pif.a_ready && pif.b_ready}, 32'd1);
    pif.a_valid = v.a_en;
    pif.a_move  = v.am;
    pif.b_valid = v.b_en;
    pif.b_move  = v.bm;
    exp_lat = (v.a_en && v.b_en) ? 2 : TIMEOUT + 1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < TIMEOUT + 6) begin
      @(negedge clk);
      lat++;
      pif.a_valid = 1'b0;
      pif.b_valid = 1'b0;
      if (round_done) seen = 1'b1;
    end
    if (v.res[1]) ma++;
    if (v.res[0]) mb++;
    check({tag, " latency"}, seen ? lat : 32'hFFFF, exp_lat);
    check({tag, " result"},  round_result, v.res);
    check({tag, " score_a"}, score_a, ma);
    check({tag, " score_b"}, score_b, mb);
  endtask

  initial begin
    // Match 1: A reaches 3 wins on a timeout forfeit.
    tbl[0]  = '{3'b100, 3'b001, 1, 1, 2'b10};  // rock beats scissors
    tbl[1]  = '{3'b001, 3'b100, 1, 1, 2'b01};  // rock beats scissors (B)
    tbl[2]  = '{3'b010, 3'b010, 1, 1, 2'b00};  // equal moves tie
    tbl[3]  = '{3'b110, 3'b010, 1, 1, 2'b01};  // malformed A loses
    tbl[4]  = '{3'b000, 3'b011, 1, 1, 2'b00};  // both malformed tie
    tbl[5]  = '{3'b000, 3'b000, 0, 0, 2'b00};  // nobody plays: timeout tie
    tbl[6]  = '{3'b010, 3'b100, 1, 1, 2'b10};  // paper beats rock
    tbl[7]  = '{3'b001, 3'b000, 1, 0, 2'b10};  // B absent: forfeit
    // Match 2: B sweeps.
    tbl[8]  = '{3'b100, 3'b010, 1, 1, 2'b01};
    tbl[9]  = '{3'b010, 3'b001, 1, 1, 2'b01};
    tbl[10] = '{3'b001, 3'b100, 1, 1, 2'b01};
    // Match 3: one round before the mid-match reset.
    tbl[11] = '{3'b100, 3'b001, 1, 1, 2'b10};

    rst_n = 1'b0;
    start = 1'b0;
    pif.a_valid = 1'b0;
    pif.b_valid = 1'b0;
    pif.a_move  = 3'b000;
    pif.b_move  = 3'b000;

    // Reset held: everything low even with a move offered.
    repeat (2) @(negedge clk);
    pif.a_valid = 1'b1;
    pif.a_move  = 3'b100;
    @(negedge clk);
    check("rst a_ready", pif.a_ready, 0);
    check("rst b_ready", pif.b_ready, 0);
    check("rst busy", busy, 0);
    check("rst outputs", {round_done, round_result, score_a, score_b, match_done, winner}, 0);
    pif.a_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 0);
    check("idle a_ready", pif.a_ready, 0);

    // Match 1.
    pulse_start();
    check("m1 busy", busy, 1);
    check("m1 scores", {score_a, score_b}, 0);
    for (int i = 0; i <= 6; i++) play(tbl[i], $sformatf("m1r%0d", i));

    // Staggered capture: A at N, B at N+4, both paper.
    @(negedge clk);
    pif.a_valid = 1'b1;
    pif.a_move  = 3'b010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      pif.a_valid = 1'b0;
      check($sformatf("stag a_ready %0d", k), pif.a_ready, 0);
      check($sformatf("stag b_ready %0d", k), pif.b_ready, 1);
      if (k == 4) begin
        pif.b_valid = 1'b1;
        pif.b_move  = 3'b010;
      end
    end
    @(negedge clk);
    pif.b_valid = 1'b0;
    check("stag no early done", round_done, 0);
    @(negedge clk);
    check("stag round_done", round_done, 1);
    check("stag result", round_result, 2'b00);
    check("stag scores", {score_a, score_b}, {SCORE_W'(2), SCORE_W'(2)});

    play(tbl[7], "m1r7");
    @(negedge clk);
    check("m1 match_done", match_done, 1);
    check("m1 winner", winner, 2'b10);
    check("m1 busy", busy, 0);
    @(negedge clk);
    check("m1 hold", {match_done, score_a, score_b, round_result},
          {1'b1, SCORE_W'(3), SCORE_W'(2), 2'b10});

    // Match 2: restart from DONE.
    pulse_start();
    check("m2 cleared", {busy, match_done, winner, score_a, score_b},
          {1'b1, 1'b0, 2'b00, SCORE_W'(0), SCORE_W'(0)});
    for (int i = 8; i <= 10; i++) play(tbl[i], $sformatf("m2r%0d", i));
    @(negedge clk);
    check("m2 match_done", match_done, 1);
    check("m2 winner", winner, 2'b01);
    check("m2 busy", busy, 0);

    // Match 3: start ignored while busy, then reset mid-COLLECT.
    pulse_start();
    play(tbl[11], "m3r0");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy start ignored", {busy, score_a}, {1'b1, SCORE_W'(1)});
    rst_n = 1'b0;
    #1;
    check("midrst ready", {pif.a_ready, pif.b_ready}, 0);
    check("midrst busy", busy, 0);
    check("midrst scores", {score_a, score_b, round_result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst idle", {busy, match_done, winner}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
